// File: rtl/apb_arbiter.sv
// apb_arbiter
// Round-robin arbiter plus APB master sequencer. It shares one APB master port
// between M requesters and runs the SETUP/ACCESS handshake for them. A PREADY
// timeout frees the bus when a slave hangs.
//
// Ports
//   clk, rst                   system clock; synchronous active-high reset
//   req_valid/req_write [M]    per-requester request and direction (1 = write)
//   req_addr/req_wdata [M*32]  per-requester address / write data, slice i at [i*32+:32]
//   req_done [M]               one-hot, single-cycle completion pulse
//   req_err                    qualifies req_done; 1 = transfer aborted by timeout
//   req_rdata [32]             read data, valid while any req_done bit is high
//   m_psel/m_penable/m_pwrite  APB control toward the interconnect
//   m_paddr/m_pwdata [32]      APB address / write data
//   m_pready, m_prdata [32]    APB slave response
//
// Parameters
//   M        number of requesters (>= 2)
//   TIMEOUT  maximum ACCESS cycles with m_pready low before abort; 0 disables it
module apb_arbiter #(
    parameter int M       = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [M-1:0]    req_valid,
    input  logic [M-1:0]    req_write,
    input  logic [M*32-1:0] req_addr,
    input  logic [M*32-1:0] req_wdata,
    output logic [M-1:0]    req_done,
    output logic            req_err,
    output logic [31:0]     req_rdata,
    output logic            m_psel,
    output logic            m_penable,
    output logic            m_pwrite,
    output logic [31:0]     m_paddr,
    output logic [31:0]     m_pwdata,
    input  logic            m_pready,
    input  logic [31:0]     m_prdata
);

    localparam int IW = (M > 1) ? $clog2(M) : 1;
    // With the timeout disabled the counter is a single saturating bit.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [IW-1:0] LAST_GRANT_INIT = IW'(M - 1);
    localparam logic [CW-1:0] CNT_LAST        = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX         = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ZERO        = {CW{1'b0}};
    localparam logic [M-1:0]  DONE_BASE       = {{(M-1){1'b0}}, 1'b1};
    localparam logic [31:0]   ABORT_RDATA     = 32'hdeadbeef;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   grant_r;
    logic [IW-1:0]   last_grant_r;
    logic [CW-1:0]   cnt_r;

    logic            pick_found_s;
    logic [IW-1:0]   pick_idx_s;
    logic [IW-1:0]   cand_s;

    // Round-robin pick: first valid requester scanning upward from last_grant+1, wrapping.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = last_grant_r;
        cand_s       = last_grant_r;
        for (int k = 1; k <= M; k++) begin
            cand_s = IW'((int'(last_grant_r) + k) % M);
            if (!pick_found_s && req_valid[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_idx_s   = pick_idx_s;
            end
        end
    end

    // Transfer sequencer: grant, SETUP, ACCESS with timeout, single-cycle DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            grant_r      <= {IW{1'b0}};
            last_grant_r <= LAST_GRANT_INIT;
            cnt_r        <= CNT_ZERO;
            m_psel       <= 1'b0;
            m_penable    <= 1'b0;
            m_pwrite     <= 1'b0;
            m_paddr      <= 32'h0000_0000;
            m_pwdata     <= 32'h0000_0000;
            req_done     <= {M{1'b0}};
            req_err      <= 1'b0;
            req_rdata    <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        grant_r      <= pick_idx_s;
                        last_grant_r <= pick_idx_s;
                        m_pwrite     <= req_write[pick_idx_s];
                        m_paddr      <= req_addr[{pick_idx_s, 5'b00000} +: 32];
                        m_pwdata     <= req_wdata[{pick_idx_s, 5'b00000} +: 32];
                        m_psel       <= 1'b1;
                        m_penable    <= 1'b0;
                        state_r      <= ST_SETUP;
                    end else begin
                        m_psel       <= 1'b0;
                        m_penable    <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    m_penable <= 1'b1;
                    cnt_r     <= CNT_ZERO;
                    state_r   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (m_pready) begin
                        // Captured on writes too; requesters ignore it then.
                        req_rdata <= m_prdata;
                        req_done  <= DONE_BASE << grant_r;
                        req_err   <= 1'b0;
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        state_r   <= ST_DONE;
                    end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
                        req_rdata <= ABORT_RDATA;
                        req_done  <= DONE_BASE << grant_r;
                        req_err   <= 1'b1;
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        state_r   <= ST_DONE;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CW'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_DONE: begin
                    req_done <= {M{1'b0}};
                    req_err  <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    m_psel    <= 1'b0;
                    m_penable <= 1'b0;
                    req_done  <= {M{1'b0}};
                    req_err   <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_arbiter.sv
module tb_apb_arbiter;

    localparam int M       = 4;
    localparam int TIMEOUT = 8;

    logic            clk;
    logic            rst;
    logic [M-1:0]    req_valid;
    logic [M-1:0]    req_write;
    logic [M*32-1:0] req_addr;
    logic [M*32-1:0] req_wdata;
    logic [M-1:0]    req_done;
    logic            req_err;
    logic [31:0]     req_rdata;
    logic            m_psel;
    logic            m_penable;
    logic            m_pwrite;
    logic [31:0]     m_paddr;
    logic [31:0]     m_pwdata;
    logic            m_pready;
    logic [31:0]     m_prdata;

    int n_vec;
    int n_err;
    int last_g;   // reference model: index of the most recent grant

    apb_arbiter #(.M(M), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .req_err   (req_err),
        .req_rdata (req_rdata),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_paddr   (m_paddr),
        .m_pwdata  (m_pwdata),
        .m_pready  (m_pready),
        .m_prdata  (m_prdata)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first valid index after last_g, modulo M.
    function automatic int model_pick();
        for (int k = 1; k <= M; k++) begin
            if (req_valid[(last_g + k) % M]) return (last_g + k) % M;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v);
        req_valid[i]         = v;
        req_write[i]         = 1'($urandom % 2);
        req_addr[i*32 +: 32] = $urandom;
        req_wdata[i*32 +: 32] = $urandom;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_psel"},    32'(m_psel),    32'h0);
        check_eq({tag, "_penable"}, 32'(m_penable), 32'h0);
        check_eq({tag, "_pwrite"},  32'(m_pwrite),  32'h0);
        check_eq({tag, "_paddr"},   m_paddr,        32'h0);
        check_eq({tag, "_pwdata"},  m_pwdata,       32'h0);
        check_eq({tag, "_done"},    32'(req_done),  32'h0);
        check_eq({tag, "_err"},     32'(req_err),   32'h0);
        check_eq({tag, "_rdata"},   req_rdata,      32'h0);
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b0;
        last_g = M - 1;
    endtask

    // One transfer starting in an IDLE cycle. The slave holds PREADY low for
    // 'waits' ACCESS cycles; rst_at >= 0 pulses reset in that ACCESS cycle.
    task automatic run_xfer(input int waits, input bit drop, input int rst_at,
                            input bit keep, input logic [31:0] rd,
                            output logic [M-1:0] done_seen);
        int          w;
        logic [31:0] ea;
        logic [31:0] ed;
        logic        ew;
        logic        exp_err;
        done_seen = '0;
        w = model_pick();
        if (w < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL no_request: got none expected a valid requester");
            return;
        end
        ea = req_addr[w*32 +: 32];
        ed = req_wdata[w*32 +: 32];
        ew = req_write[w];
        last_g = w;
        tick();
        // SETUP cycle
        check_eq("setup_psel",    32'(m_psel),    32'h1);
        check_eq("setup_penable", 32'(m_penable), 32'h0);
        check_eq("setup_paddr",   m_paddr,        ea);
        check_eq("setup_pwdata",  m_pwdata,       ed);
        check_eq("setup_pwrite",  32'(m_pwrite),  32'(ew));
        check_eq("setup_done",    32'(req_done),  32'h0);
        if (drop) begin
            req_valid[w]          = 1'b0;
            req_addr[w*32 +: 32]  = ~ea;
            req_wdata[w*32 +: 32] = ~ed;
        end
        tick();
        for (int j = 0; j < waits + TIMEOUT + 2; j++) begin
            check_eq("acc_psel",    32'(m_psel),    32'h1);
            check_eq("acc_penable", 32'(m_penable), 32'h1);
            check_eq("acc_paddr",   m_paddr,        ea);
            check_eq("acc_pwdata",  m_pwdata,       ed);
            check_eq("acc_pwrite",  32'(m_pwrite),  32'(ew));
            check_eq("acc_done",    32'(req_done),  32'h0);
            if (j == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_reset_vals("midrst");
                last_g = M - 1;
                return;
            end
            m_pready = (j >= waits);
            m_prdata = (j >= waits) ? rd : $urandom;
            tick();
            m_pready = 1'b0;
            if (j >= waits || j == TIMEOUT - 1) break;
        end
        // DONE cycle
        exp_err = (waits >= TIMEOUT);
        check_eq("done_vec",     32'(req_done),  32'(1) << w);
        check_eq("done_err",     32'(req_err),   32'(exp_err));
        check_eq("done_rdata",   req_rdata,      exp_err ? 32'hdeadbeef : rd);
        check_eq("done_psel",    32'(m_psel),    32'h0);
        check_eq("done_penable", 32'(m_penable), 32'h0);
        done_seen = req_done;
        set_req(w, keep);
        tick();
        // back in IDLE
        check_eq("idle_done",    32'(req_done),  32'h0);
        check_eq("idle_err",     32'(req_err),   32'h0);
        check_eq("idle_psel",    32'(m_psel),    32'h0);
        check_eq("idle_penable", 32'(m_penable), 32'h0);
    endtask

    initial begin
        logic [M-1:0] ds;
        logic [M-1:0] rr_exp [5];
        n_vec = 0;
        n_err = 0;
        last_g = M - 1;
        rst = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        m_pready  = 1'b0;
        m_prdata  = 32'h0;

        // Reset state
        do_reset();

        // Single read from requester 1
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[32 +: 32] = 32'h0002_0010;
        run_xfer(0, 1'b0, -1, 1'b0, 32'h1234_5678, ds);
        check_eq("single_read_who", 32'(ds), 32'h2);

        // Round robin among 0, 2, 3 from reset
        do_reset();
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0100;
        rr_exp[2] = 4'b1000;
        rr_exp[3] = 4'b0001;
        rr_exp[4] = 4'b0100;
        set_req(0, 1'b1);
        set_req(2, 1'b1);
        set_req(3, 1'b1);
        for (int k = 0; k < 5; k++) begin
            run_xfer(0, 1'b0, -1, 1'b1, $urandom, ds);
            check_eq("rr_order", 32'(ds), 32'(rr_exp[k]));
        end

        // Write with five wait states
        do_reset();
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[32 +: 32]  = 32'h0001_0004;
        req_wdata[32 +: 32] = 32'hCAFE_F00D;
        run_xfer(5, 1'b0, -1, 1'b0, $urandom, ds);

        // Timeout, then a normal transfer
        req_valid = '0;
        set_req(2, 1'b1);
        run_xfer(20, 1'b0, -1, 1'b1, $urandom, ds);
        run_xfer(1, 1'b0, -1, 1'b0, $urandom, ds);
        check_eq("after_timeout_who", 32'(ds), 32'h4);

        // Reset mid-ACCESS during requester 0's transfer; 0 wins again afterwards
        req_valid = '0;
        set_req(0, 1'b1);
        run_xfer(5, 1'b0, 2, 1'b0, $urandom, ds);
        set_req(1, 1'b1);
        run_xfer(0, 1'b0, -1, 1'b0, $urandom, ds);
        check_eq("post_reset_who", 32'(ds), 32'h1);

        // Valid dropped during SETUP
        req_valid = '0;
        set_req(2, 1'b1);
        run_xfer(2, 1'b1, -1, 1'b0, $urandom, ds);
        check_eq("drop_who", 32'(ds), 32'h4);

        // Randomized traffic against the reference model
        for (int it = 0; it < 200; it++) begin
            for (int i = 0; i < M; i++) begin
                if (!req_valid[i] && ($urandom % 3 == 0)) set_req(i, 1'b1);
            end
            if (req_valid == '0) begin
                tick();
                check_eq("rand_idle_psel", 32'(m_psel), 32'h0);
                continue;
            end
            run_xfer($urandom_range(0, 10), ($urandom % 4 == 0),
                     ($urandom % 16 == 0) ? $urandom_range(0, 2) : -1,
                     1'($urandom % 2), $urandom, ds);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
- Round-robin arbiter and APB master sequencer that shares one APB master port between M independent requesters (CPU bridge, DMA config engine, debug UART, etc.).
- Its APB master port drives the upstream side of the APB interconnect, which decodes `paddr[16+]` to slaves.
- Performs the SETUP and ACCESS phase sequencing on behalf of requesters.
- Guards against hung slaves with a PREADY timeout.

Parameters:
- M, 2, number of requesters (≥2).
- TIMEOUT, 1023, max ACCESS cycles with `m_pready` low before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  M  per-requester transaction request; held stable until its `req_done`.
- req_write  in  M  per-requester 1=write, 0=read.
- req_addr  in  M*32  per-requester address, slice i at [i*32+:32].
- req_wdata  in  M*32  per-requester write data, slice i at [i*32+:32].
- req_done  out  M  one-hot, single-cycle completion pulse to the granted requester.
- req_err  out  1  qualifies `req_done`; 1 = transfer aborted by timeout.
- req_rdata  out  32  read data, valid only while any `req_done` bit is high.
- m_psel  out  1  APB PSEL toward interconnect.
- m_penable  out  1  APB PENABLE.
- m_pwrite  out  1  APB PWRITE.
- m_paddr  out  32  APB PADDR.
- m_pwdata  out  32  APB PWDATA.
- m_pready  in  1  APB PREADY.
- m_prdata  in  32  APB PRDATA.

Behaviour:
- All outputs are registered. Reset values: `m_psel`, `m_penable`, `m_pwrite`, `req_done`, `req_err` = 0; `m_paddr`, `m_pwdata`, `req_rdata` = 0; state = IDLE; `last_grant` = M-1, so requester 0 has first priority; timeout counter = 0.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If any `req_valid` is set, pick the first set bit scanning from `last_grant+1` upward, wrapping modulo M.
  - Latch the winner's index, write, addr and wdata into `m_*`. Set `last_grant` = winner.
  - Next cycle: `m_psel`=1, `m_penable`=0, state → SETUP.
  - With no request, stay in IDLE with `m_psel`=0.
- SETUP: lasts exactly one cycle. Next cycle `m_penable`=1, state → ACCESS, counter cleared.
- ACCESS:
  - `m_paddr`, `m_pwdata` and `m_pwrite` stay stable throughout.
  - If `m_pready`=1: capture `m_prdata` into `req_rdata` (also captured on writes; contents don't care). Next cycle `m_psel`=`m_penable`=0, `req_done[grant]`=1, `req_err`=0, state → DONE.
  - Else if TIMEOUT≠0 and counter == TIMEOUT-1: abort. Next cycle `m_psel`=`m_penable`=0, `req_done[grant]`=1, `req_err`=1, `req_rdata`=32'hdeadbeef, state → DONE.
  - Else the counter increments; its width is $clog2(TIMEOUT+1) and it never wraps.
- DONE:
  - `req_done` is high for this single cycle. `req_valid` is ignored during DONE.
  - Next cycle `req_done`=0, `req_err`=0, state → IDLE.
  - A requester still asserting valid in IDLE is treated as a new request.
- Latency: a request accepted in IDLE at cycle T gives SETUP at T+1, ACCESS at T+2, and `req_done` at T+3 + (wait states). Minimum spacing is 4 cycles per transfer.
- Fairness: a requester holding valid continuously cannot be granted twice in a row while another requester is valid.
- Requester validity changes:
  - `req_valid` dropping mid-transfer does not abort; the transfer completes and `done` is still pulsed.
  - Changes to the granted requester's addr/wdata after grant are ignored, because they are latched in IDLE.
- `rst` asserted in any state: on the next edge all outputs return to reset values. No `req_done` is emitted for the interrupted transfer, and `m_psel` drops immediately.
- `m_penable` is never 1 while `m_psel`=0. `req_done` is never more than one-hot.

Test Plan:
1. Single read: requester 1 valid, addr 0x0002_0010, slave `pready`=1 in the first ACCESS cycle, `prdata`=0x1234_5678 → `m_psel` high at T+1, `m_penable` high at T+2, `req_done`=0b10 at T+3, `req_rdata`=0x1234_5678, `req_err`=0.
2. Round robin (M=4): requesters 0, 2 and 3 valid continuously from reset → grant order 0, 2, 3, 0, 2. Each `req_done` is a single-cycle one-hot pulse, and grants are 4 cycles apart.
3. Wait states: write 0xCAFEF00D to 0x0001_0004 with `pready` low for 5 ACCESS cycles → `m_paddr`/`m_pwdata`/`m_pwrite` stable for 6 ACCESS cycles, then done at T+8, `err`=0.
4. Timeout (TIMEOUT=8): `pready` held at 0 → exactly 8 ACCESS cycles, then `psel`/`penable` drop, `req_done` pulses, `req_err`=1, `req_rdata`=32'hdeadbeef, and the next request proceeds normally.
5. Reset mid-ACCESS: assert `rst` for 1 cycle during a wait state → next cycle `m_psel`=`m_penable`=0 and `req_done`=0. After reset, requester 0 wins even if requester 1 had been granted before.
6. Valid dropped mid-transfer: requester 2 deasserts valid during SETUP → transfer still completes, with `req_done[2]` pulsed once.
